// File: rtl/tia_hphase_ctrl_pkg.sv
// Shared constants and LFSR helpers for the TIA horizontal phase sequencer.
package tia_hphase_ctrl_pkg;

  localparam int unsigned CNT_W = 6;
  localparam int unsigned PH_W  = 2;

  localparam logic [PH_W-1:0] PH_S1       = PH_W'(0);
  localparam logic [PH_W-1:0] PH_ADV_FROM = PH_W'(1);
  localparam logic [PH_W-1:0] PH_S2       = PH_W'(2);
  localparam logic [PH_W-1:0] PH_RESET    = PH_W'(3);

  // XNOR feedback on taps 6,5: maximal length 63, all-ones is the lock-up state.
  function automatic logic [CNT_W-1:0] lfsr_next(input logic [CNT_W-1:0] v);
    return {v[CNT_W-2:0], ~(v[CNT_W-1] ^ v[CNT_W-2])};
  endfunction

  // State reached after n advances from zero.
  function automatic logic [CNT_W-1:0] lfsr_at(input int unsigned n);
    logic [CNT_W-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < n; i++) v = lfsr_next(v);
    return v;
  endfunction

endpackage

// File: rtl/tia_hphase_ctrl_lfsr.sv
// Horizontal polynomial counter: advances on request, zeroes on wrap or clear.
// TIA_HPHASE_BINIDX_EN adds a binary index that tracks the LFSR position.
module tia_hphase_ctrl_lfsr
  import tia_hphase_ctrl_pkg::*;
#(
  parameter int unsigned PERIOD = 57
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             advance,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output logic             at_end_c
`ifdef TIA_HPHASE_BINIDX_EN
  ,
  output logic [CNT_W-1:0] idx
`endif
);

  localparam logic [CNT_W-1:0] END_STATE = lfsr_at(PERIOD - 1);

  assign at_end_c = (count == END_STATE);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (advance) begin
      count <= (clear || at_end_c) ? '0 : lfsr_next(count);
    end
  end

`ifdef TIA_HPHASE_BINIDX_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      idx <= '0;
    end else if (advance) begin
      idx <= (clear || at_end_c) ? '0 : idx + CNT_W'(1);
    end
  end
`endif

endmodule

// File: rtl/tia_hphase_ctrl.sv
// TIA two-phase clock sequencer: s1/s2 strobes, line counter, RSYNC and WSYNC.
// Optional TIA_HPHASE_BINIDX_EN exposes a binary line index on idx.
module tia_hphase_ctrl
  import tia_hphase_ctrl_pkg::*;
#(
  parameter int unsigned PERIOD = 57
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             rsync,
  input  logic             wsync_req,
  output logic             s1,
  output logic             s2,
  output logic [CNT_W-1:0] count,
  output logic             wrap,
  output logic             rdy
`ifdef TIA_HPHASE_BINIDX_EN
  ,
  output logic [CNT_W-1:0] idx
`endif
);

  logic [PH_W-1:0] p, p_d;
  logic            s1_d, s2_d, wrap_d, rdy_d;
  logic            rsync_pend, rsync_pend_d;
  logic            adv_c, clr_c, at_end_c, release_c;

  tia_hphase_ctrl_lfsr #(.PERIOD(PERIOD)) u_lfsr (
    .clk      (clk),
    .reset    (reset),
    .advance  (adv_c),
    .clear    (clr_c),
    .count    (count),
    .at_end_c (at_end_c)
`ifdef TIA_HPHASE_BINIDX_EN
    ,
    .idx      (idx)
`endif
  );

  // Next-state: phase stepping, advance decode, rsync/wsync bookkeeping.
  always_comb begin
    p_d          = p;
    s1_d         = 1'b0;
    s2_d         = 1'b0;
    wrap_d       = 1'b0;
    rdy_d        = rdy;
    rsync_pend_d = rsync_pend;
    adv_c        = 1'b0;
    clr_c        = 1'b0;
    release_c    = 1'b0;
    if (run) begin
      p_d          = p + PH_W'(1);
      s1_d         = (p_d == PH_S1);
      s2_d         = (p_d == PH_S2);
      adv_c        = (p == PH_ADV_FROM);
      clr_c        = adv_c && (rsync_pend || rsync);
      // An rsync load suppresses the natural wrap pulse on the same edge.
      wrap_d       = adv_c && at_end_c && !clr_c;
      rsync_pend_d = adv_c ? 1'b0 : (rsync_pend || rsync);
      release_c    = clr_c || wrap_d;
      if (release_c) begin
        rdy_d = !wsync_req;
      end else if (wsync_req) begin
        rdy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p          <= PH_RESET;
      s1         <= 1'b0;
      s2         <= 1'b0;
      wrap       <= 1'b0;
      rdy        <= 1'b1;
      rsync_pend <= 1'b0;
    end else begin
      p          <= p_d;
      s1         <= s1_d;
      s2         <= s2_d;
      wrap       <= wrap_d;
      rdy        <= rdy_d;
      rsync_pend <= rsync_pend_d;
    end
  end

endmodule

// File: tb/tb_tia_hphase_ctrl.sv
// Self-checking bench for tia_hphase_ctrl: vector table, scoreboard model, line-timing sequences.
module tb_tia_hphase_ctrl;

  localparam int unsigned PERIOD = 57;

  logic       clk = 1'b0;
  logic       reset, run, rsync, wsync_req;
  logic       s1, s2, wrap, rdy;
  logic [5:0] count;
`ifdef TIA_HPHASE_BINIDX_EN
  logic [5:0] idx;
`endif

  always #5 clk = ~clk;

  tia_hphase_ctrl #(.PERIOD(PERIOD)) dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .rsync     (rsync),
    .wsync_req (wsync_req),
    .s1        (s1),
    .s2        (s2),
    .count     (count),
    .wrap      (wrap),
    .rdy       (rdy)
`ifdef TIA_HPHASE_BINIDX_EN
    ,
    .idx       (idx)
`endif
  );

  typedef struct packed {
    logic       s1, s2;
    logic [5:0] cnt;
    logic       wrap, rdy;
    logic [5:0] idx;
  } exp_t;

  typedef struct {
    bit         rst, run, rs, ws;
    logic       s1, s2;
    logic [5:0] cnt;
    logic       wrap, rdy;
  } vec_t;

  exp_t sb[$];
  int   wrap_edges[$];
  int   n_chk = 0, n_fail = 0, cyc = 0;

  // Reference model keeps a line position and derives the LFSR value from it.
  int m_p = 3, m_idx = 0;
  bit m_s1, m_s2, m_wrap, m_rdy = 1'b1, m_pend;

  function automatic logic [5:0] ref_lfsr(input int n);
    logic [5:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v = {v[4:0], ~(v[5] ^ v[4])};
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp_v);
    n_chk++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", nm, cyc, act, exp_v);
    end
  endtask

  task automatic model_step(input bit r, input bit rn, input bit rs, input bit ws);
    bit adv, rel;
    if (r) begin
      m_p = 3; m_idx = 0; m_s1 = 0; m_s2 = 0; m_wrap = 0; m_rdy = 1; m_pend = 0;
    end else if (!rn) begin
      m_s1 = 0; m_s2 = 0; m_wrap = 0;
    end else begin
      adv = (m_p == 1);
      rel = 0;
      m_wrap = 0;
      if (adv) begin
        if (m_pend || rs) begin
          m_idx = 0; rel = 1;
        end else if (m_idx == int'(PERIOD) - 1) begin
          m_idx = 0; rel = 1; m_wrap = 1;
        end else begin
          m_idx++;
        end
      end
      m_pend = adv ? 1'b0 : (m_pend | rs);
      if (rel) m_rdy = !ws;
      else if (ws) m_rdy = 0;
      m_p = (m_p + 1) % 4;
      m_s1 = (m_p == 0);
      m_s2 = (m_p == 2);
    end
  endtask

  task automatic step(input bit r, input bit rn, input bit rs, input bit ws);
    exp_t e;
    reset = r; run = rn; rsync = rs; wsync_req = ws;
    model_step(r, rn, rs, ws);
    sb.push_back('{m_s1, m_s2, ref_lfsr(m_idx), m_wrap, m_rdy, 6'(m_idx)});
    @(posedge clk);
    @(negedge clk);
    cyc = r ? 0 : cyc + 1;
    if (r) wrap_edges.delete();
    e = sb.pop_front();
    chk("s1", int'(s1), int'(e.s1));
    chk("s2", int'(s2), int'(e.s2));
    chk("count", int'(count), int'(e.cnt));
    chk("wrap", int'(wrap), int'(e.wrap));
    chk("rdy", int'(rdy), int'(e.rdy));
`ifdef TIA_HPHASE_BINIDX_EN
    chk("idx", int'(idx), int'(e.idx));
`endif
    if (wrap === 1'b1) wrap_edges.push_back(cyc);
  endtask

  task automatic run_to(input int e);
    while (cyc < e) step(0, 1, 0, 0);
  endtask

  task automatic chk_one_wrap(input string nm, input int e1);
    chk({nm, "_wrap_n"}, wrap_edges.size(), 1);
    if (wrap_edges.size() >= 1) chk({nm, "_wrap_edge"}, wrap_edges[0], e1);
  endtask

  vec_t tbl[9];

  initial begin
    reset = 1; run = 0; rsync = 0; wsync_req = 0;
    //          rst run rs ws  s1 s2 cnt         wrap rdy
    tbl[0] = '{1, 0, 0, 0, 0, 0, 6'b000000, 0, 1};
    tbl[1] = '{0, 1, 0, 0, 1, 0, 6'b000000, 0, 1};
    tbl[2] = '{0, 1, 0, 0, 0, 0, 6'b000000, 0, 1};
    tbl[3] = '{0, 1, 0, 0, 0, 1, 6'b000001, 0, 1};
    tbl[4] = '{0, 1, 0, 0, 0, 0, 6'b000001, 0, 1};
    tbl[5] = '{0, 1, 0, 0, 1, 0, 6'b000001, 0, 1};
    tbl[6] = '{0, 1, 0, 0, 0, 0, 6'b000001, 0, 1};
    tbl[7] = '{0, 1, 0, 0, 0, 1, 6'b000011, 0, 1};
    tbl[8] = '{0, 1, 0, 0, 0, 0, 6'b000011, 0, 1};

    // Reset state and first two phase cycles from the vector table.
    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].run, tbl[i].rs, tbl[i].ws);
      chk("tbl_s1", int'(s1), int'(tbl[i].s1));
      chk("tbl_s2", int'(s2), int'(tbl[i].s2));
      chk("tbl_count", int'(count), int'(tbl[i].cnt));
      chk("tbl_wrap", int'(wrap), int'(tbl[i].wrap));
      chk("tbl_rdy", int'(rdy), int'(tbl[i].rdy));
    end

    // Two full lines: wraps at 227 and 455 only.
    run_to(223);
`ifdef TIA_HPHASE_BINIDX_EN
    chk("idx_at_223", int'(idx), 56);
`endif
    run_to(455);
    chk("count_at_455", int'(count), 0);
    run_to(460);
    chk("line_wrap_n", wrap_edges.size(), 2);
    if (wrap_edges.size() >= 2) begin
      chk("line_wrap_1", wrap_edges[0], 227);
      chk("line_wrap_2", wrap_edges[1], 455);
    end

    // RSYNC mid-line: zero at next advance, no wrap, line restarts.
    step(1, 0, 0, 0);
    run_to(100);
    step(0, 1, 1, 0);
    run_to(102);
    chk("rsync_cnt_102", int'(count), int'(ref_lfsr(25)));
    run_to(103);
    chk("rsync_cnt_103", int'(count), 0);
    chk("rsync_nowrap", int'(wrap), 0);
    run_to(340);
    chk_one_wrap("rsync", 331);

    // WSYNC: rdy low until end of line, repeated request ignored.
    step(1, 0, 0, 0);
    run_to(50);
    step(0, 1, 0, 1);
    chk("wsync_rdy_51", int'(rdy), 0);
    run_to(59);
    step(0, 1, 0, 1);
    run_to(226);
    chk("wsync_rdy_226", int'(rdy), 0);
    step(0, 1, 0, 0);
    chk("wsync_rdy_227", int'(rdy), 1);

    // WSYNC on the release edge holds rdy low for another line.
    step(1, 0, 0, 0);
    run_to(226);
    step(0, 1, 0, 1);
    chk("wsync_edge_rdy_227", int'(rdy), 0);
    run_to(454);
    chk("wsync_edge_rdy_454", int'(rdy), 0);
    step(0, 1, 0, 0);
    chk("wsync_edge_rdy_455", int'(rdy), 1);

    // run=0 for 10 clocks shifts the line by 10.
    step(1, 0, 0, 0);
    run_to(100);
    repeat (10) step(0, 0, 0, 0);
    chk("freeze_count", int'(count), int'(ref_lfsr(25)));
    step(0, 1, 0, 0);
    chk("resume_s1", int'(s1), 1);
    run_to(245);
    chk_one_wrap("freeze", 237);

    // Reset with rsync pending and rdy low: clean restart, no stray zero load.
    step(1, 0, 0, 0);
    run_to(140);
    step(0, 1, 0, 1);
    run_to(148);
    step(0, 1, 1, 0);
    chk("pre_reset_rdy", int'(rdy), 0);
    step(1, 0, 0, 0);
    chk("post_reset_rdy", int'(rdy), 1);
    chk("post_reset_count", int'(count), 0);
    run_to(7);
    chk("post_reset_cnt_7", int'(count), 3);
    run_to(240);
    chk_one_wrap("post_reset", 227);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
